// File: rtl/adjust_v_pkg.sv
// Shared types and constants for the V-channel adjust frame sequencer.
package adjust_v_pkg;

   localparam int unsigned PIXEL_W  = 8;
   localparam int unsigned ADJV_LAT = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN,
      DONE
   } adjv_state_e;

endpackage

// File: rtl/adjust_v_ctrl_if.sv
// Pixel-path signals between the sequencer (master), the adjust pipeline and the output sink.
interface adjust_v_ctrl_if;
   import adjust_v_pkg::*;

   logic [PIXEL_W-1:0] adj_from_v;
   logic [PIXEL_W-1:0] adj_to_v;
   logic               adj_req;
   logic               src_ack_mon;
   logic               adj_ack;
   logic [PIXEL_W-1:0] adj_pixel;
   logic               out_valid;
   logic [PIXEL_W-1:0] out_pixel;
   logic               out_ready;

   modport master (
      output adj_from_v, adj_to_v, adj_req, out_valid, out_pixel,
      input  src_ack_mon, adj_ack, adj_pixel, out_ready
   );

   modport slave (
      input  adj_from_v, adj_to_v, adj_req, out_valid, out_pixel,
      output src_ack_mon, adj_ack, adj_pixel, out_ready
   );

endinterface

// File: rtl/adjust_v_ctrl_fifo.sv
// Synchronous output FIFO; no bypass, so pushed data is visible the cycle after the push.
module adjust_v_ctrl_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       xrst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == (PTR_W + 1)'(DEPTH));
   assign empty = (count == '0);

   // A pop in the same cycle frees the slot, so push-when-full is legal then.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adjust_v_ctrl.sv
// Frame sequencer for the V-adjust pipeline: per-frame parameter latch, credit-limited requests,
// output FIFO. Define ADJV_CTRL_PERF_EN to add the perf_cycles/perf_stall counters.
module adjust_v_ctrl
   import adjust_v_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LEN_W      = 20
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               start,
   input  logic [LEN_W-1:0]   frame_len,
   input  logic               cfg_wr,
   input  logic [PIXEL_W-1:0] cfg_from_v,
   input  logic [PIXEL_W-1:0] cfg_to_v,
   output logic               busy,
   output logic               done,
`ifdef ADJV_CTRL_PERF_EN
   output logic [LEN_W+3:0]   perf_cycles,
   output logic [LEN_W+3:0]   perf_stall,
`endif
   adjust_v_ctrl_if.master    bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH <= ADJV_LAT)
   begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, >= 4 and deeper than the pipeline");
   end

   adjv_state_e        state;
   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   issued;
   logic [LEN_W-1:0]   received;
   logic [PIXEL_W-1:0] shadow_from_v;
   logic [PIXEL_W-1:0] shadow_to_v;
   logic [PIXEL_W-1:0] active_from_v;
   logic [PIXEL_W-1:0] active_to_v;

   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic [LEN_W:0]     credit;
   logic               has_work;
   logic               credit_ok;
   logic               req;
   logic               issue;

   // Credit covers both occupied FIFO slots and pixels still inside the pipeline.
   assign credit    = (LEN_W + 1)'(FIFO_DEPTH) - (LEN_W + 1)'(fifo_count)
                      - {1'b0, issued - received};
   assign has_work  = (issued < len_reg);
   assign credit_ok = (credit != '0) && !fifo_full;
   assign req       = (state == RUN) && has_work && credit_ok;
   // Acks without a request are a protocol error and are not counted.
   assign issue     = bus.src_ack_mon && req;
   assign pop       = bus.out_valid && bus.out_ready;

   assign bus.adj_req    = req;
   assign bus.adj_from_v = active_from_v;
   assign bus.adj_to_v   = active_to_v;
   assign bus.out_valid  = !fifo_empty;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         shadow_from_v <= '0;
         shadow_to_v   <= '0;
      end else if (cfg_wr) begin
         shadow_from_v <= cfg_from_v;
         shadow_to_v   <= cfg_to_v;
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state         <= IDLE;
         len_reg       <= '0;
         issued        <= '0;
         received      <= '0;
         active_from_v <= '0;
         active_to_v   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               issued   <= '0;
               received <= '0;
               if (start) begin
                  len_reg <= frame_len;
                  busy    <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               active_from_v <= shadow_from_v;
               active_to_v   <= shadow_to_v;
               if (len_reg == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (issue)       issued   <= issued + 1'b1;
               if (bus.adj_ack) received <= received + 1'b1;
               if (issued == len_reg) state <= DRAIN;
            end
            DRAIN: begin
               if (bus.adj_ack) received <= received + 1'b1;
               if (received == len_reg && fifo_empty) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADJV_CTRL_PERF_EN
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (state == LOAD) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         if (state == RUN || state == DRAIN) perf_cycles <= perf_cycles + 1'b1;
         if (state == RUN && has_work && !credit_ok) perf_stall <= perf_stall + 1'b1;
      end
   end
`endif

   adjust_v_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIXEL_W)
   ) u_fifo (
      .clk       (clk),
      .xrst      (xrst),
      .push      (bus.adj_ack),
      .push_data (bus.adj_pixel),
      .pop       (pop),
      .pop_data  (bus.out_pixel),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_adjust_v_ctrl.sv
// Bench for adjust_v_ctrl: table of frames plus hand-written backpressure, cfg and reset cases.
module tb_adjust_v_ctrl;
   import adjust_v_pkg::*;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned LEN_W      = 20;

   logic             clk = 1'b0;
   logic             xrst = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] frame_len = '0;
   logic             cfg_wr = 1'b0;
   logic [7:0]       cfg_from_v = '0;
   logic [7:0]       cfg_to_v = '0;
   logic             busy;
   logic             done;
`ifdef ADJV_CTRL_PERF_EN
   logic [LEN_W+3:0] perf_cycles;
   logic [LEN_W+3:0] perf_stall;
`endif

   adjust_v_ctrl_if bus ();

   adjust_v_ctrl #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk        (clk),
      .xrst       (xrst),
      .start      (start),
      .frame_len  (frame_len),
      .cfg_wr     (cfg_wr),
      .cfg_from_v (cfg_from_v),
      .cfg_to_v   (cfg_to_v),
      .busy       (busy),
      .done       (done),
`ifdef ADJV_CTRL_PERF_EN
      .perf_cycles(perf_cycles),
      .perf_stall (perf_stall),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int fv;
      int tv;
      int ack_pct;
      int rdy_pct;
      int req_lat;   // -1: adj_req must never rise
      int done_lat;  // 0: not checked
   } vec_t;

   vec_t vecs[7];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ack_pct = 100, rdy_pct = 100;
   bit start_pend = 0, cfg_pend = 0;
   int start_cyc, req_cyc, done_cyc;
   bit req_seen;
   int done_cnt, pops, n_acks, occ;
   int order_err, occ_err, ovf_err, param_bad;
   int seq = 0;
   logic [7:0] exp_fv = '0, exp_tv = '0;
   logic       pv [ADJV_LAT];
   logic [7:0] pd [ADJV_LAT];
   logic [7:0] expq[$];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      done_cnt = 0; req_seen = 0; pops = 0; n_acks = 0;
      order_err = 0; occ_err = 0; ovf_err = 0; param_bad = 0;
   endtask

   task automatic flush_model();
      for (int i = 0; i < ADJV_LAT; i++) begin
         pv[i] = 1'b0;
         pd[i] = '0;
      end
      expq.delete();
      occ = 0;
   endtask

   // One cycle: sample at negedge, then drive the inputs for the next posedge.
   task automatic tick();
      logic pop, push, s;
      logic [7:0] px;
      @(negedge clk);
      cyc++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.adj_req && !req_seen) begin
         req_seen = 1;
         req_cyc  = cyc;
      end
      if (bus.adj_req && (bus.adj_from_v != exp_fv || bus.adj_to_v != exp_tv)) param_bad++;
      if (bus.out_valid != (occ != 0)) occ_err++;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      pop = bus.out_valid && bus.out_ready;
      if (pop) begin
         pops++;
         if (expq.size() == 0) order_err++;
         else begin
            if (expq[0] != bus.out_pixel) order_err++;
            void'(expq.pop_front());
         end
      end
      bus.adj_ack   = pv[ADJV_LAT-1];
      bus.adj_pixel = pd[ADJV_LAT-1];
      for (int i = ADJV_LAT - 1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      s = bus.adj_req && ($urandom_range(0, 99) < ack_pct);
      bus.src_ack_mon = s;
      pv[0] = s;
      pd[0] = '0;
      if (s) begin
         px = 8'(seq * 5 + 3);
         seq++;
         n_acks++;
         pd[0] = px;
         expq.push_back(px);
      end
      push = bus.adj_ack;
      if (push && occ == FIFO_DEPTH && !pop) ovf_err++;
      occ = occ + int'(push) - int'(pop);
      start = start_pend;
      if (start_pend) begin
         start_cyc  = cyc;
         start_pend = 0;
      end
      cfg_wr   = cfg_pend;
      cfg_pend = 0;
   endtask

   task automatic write_cfg(input int fv, input int tv);
      cfg_from_v = 8'(fv);
      cfg_to_v   = 8'(tv);
      cfg_pend   = 1;
      tick();
   endtask

   task automatic start_frame(input int len);
      frame_len  = LEN_W'(len);
      start_pend = 1;
      tick();
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
   endtask

   task automatic check_frame(input string tag, input int len);
      check({tag, "_pops"}, pops, len);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_order_err"}, order_err, 0);
      check({tag, "_occ_err"}, occ_err + ovf_err, 0);
      check({tag, "_param_bad"}, param_bad, 0);
      check({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{16,   64, 192, 100, 100,  2, 22};
      vecs[1] = '{0,    64, 192, 100, 100, -1,  2};
      vecs[2] = '{1,    17,  33, 100, 100,  2,  7};
      vecs[3] = '{8,    99,   1, 100, 100,  2, 14};
      vecs[4] = '{9,   100,  50,  50,  80,  2,  0};
      vecs[5] = '{37,    3, 250,  60,  40,  2,  0};
      vecs[6] = '{1000,  5, 250,  70,  60,  2,  0};

      bus.src_ack_mon = 1'b0;
      bus.adj_ack     = 1'b0;
      bus.adj_pixel   = '0;
      bus.out_ready   = 1'b0;
      flush_model();
      clear_stats();

      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_adj_req", int'(bus.adj_req), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_from_v", int'(bus.adj_from_v), 0);
      check("rst_to_v", int'(bus.adj_to_v), 0);
      check("rst_out_pixel", int'(bus.out_pixel), 0);
      xrst = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         clear_stats();
         ack_pct = vecs[v].ack_pct;
         rdy_pct = vecs[v].rdy_pct;
         write_cfg(vecs[v].fv, vecs[v].tv);
         exp_fv = 8'(vecs[v].fv);
         exp_tv = 8'(vecs[v].tv);
         start_frame(vecs[v].len);
         wait_done(vecs[v].len * 8 + 100);
         tick();
         check_frame(tag, vecs[v].len);
         if (vecs[v].req_lat < 0) check({tag, "_req_seen"}, int'(req_seen), 0);
         else check({tag, "_req_lat"}, req_cyc - start_cyc, vecs[v].req_lat);
         if (vecs[v].done_lat != 0)
            check({tag, "_done_lat"}, done_cyc - start_cyc, vecs[v].done_lat);
      end

      // Backpressure: credit stops requests at FIFO_DEPTH; a start while busy is ignored.
      clear_stats();
      ack_pct = 100;
      rdy_pct = 0;
      write_cfg(64, 192);
      exp_fv = 8'd64;
      exp_tv = 8'd192;
      start_frame(20);
      repeat (30) tick();
      check("bp_issued", n_acks, 8);
      check("bp_adj_req", int'(bus.adj_req), 0);
      check("bp_fifo_occ", occ, 8);
      check("bp_out_valid", int'(bus.out_valid), 1);
      start_pend = 1;
      tick();
      rdy_pct = 100;
      wait_done(300);
      tick();
      check_frame("bp", 20);
      repeat (4) tick();
      check("bp_start_ignored_busy", int'(busy), 0);
      check("bp_start_ignored_done", done_cnt, 1);

      // Mid-frame cfg_wr only affects the next frame.
      clear_stats();
      start_frame(16);
      for (int i = 0; i < 100 && n_acks < 5; i++) tick();
      write_cfg(10, 200);
      wait_done(200);
      tick();
      check_frame("cfg_f1", 16);
      check("cfg_f1_from_v_held", int'(bus.adj_from_v), 64);
      check("cfg_f1_to_v_held", int'(bus.adj_to_v), 192);
      clear_stats();
      exp_fv = 8'd10;
      exp_tv = 8'd200;
      start_frame(16);
      wait_done(200);
      tick();
      check_frame("cfg_f2", 16);
      check("cfg_f2_from_v", int'(bus.adj_from_v), 10);
      check("cfg_f2_to_v", int'(bus.adj_to_v), 200);

      // Asynchronous reset with issued=5, received=3.
      clear_stats();
      start_frame(20);
      for (int i = 0; i < 100 && n_acks < 5; i++) tick();
      ack_pct = 0;
      tick();
      #2 xrst = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_adj_req", int'(bus.adj_req), 0);
      check("arst_out_valid", int'(bus.out_valid), 0);
      check("arst_from_v", int'(bus.adj_from_v), 0);
      check("arst_to_v", int'(bus.adj_to_v), 0);
      check("arst_out_pixel", int'(bus.out_pixel), 0);
      bus.adj_ack     = 1'b0;
      bus.src_ack_mon = 1'b0;
      flush_model();
      repeat (2) tick();
      xrst = 1'b1;
      clear_stats();
      ack_pct = 100;
      rdy_pct = 100;
      exp_fv  = 8'd0;
      exp_tv  = 8'd0;
      start_frame(16);
      wait_done(200);
      tick();
      check_frame("post_rst", 16);
      check("post_rst_done_lat", done_cyc - start_cyc, 22);
`ifdef ADJV_CTRL_PERF_EN
      check("perf_cycles", int'(perf_cycles), 20);
      check("perf_stall", int'(perf_stall), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
